fxp_mul_arb: RTL
================

# fxp_mul_arb

Round-robin arbiter and 2-stage pipeline that shares one Q(N-F).F fixed-point multiplier (`fxp_mul`) between NREQ requesters. Each requester offers an operand pair on a valid/ready port. The block returns results on one shared valid/ready response stream, tagged with the requester index and a saturation flag. It sits between the conv/MLP lane controllers and the single DSP-backed multiplier per tile.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `N`, 8: operand and result width, signed two's complement.
- `F`, 7: fractional bits, 0 < F < N.
- `IDW`, $clog2(NREQ): width of `rsp_id`.
- `clk`, in, 1: single clock; all logic is rising-edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `req_valid`, in, NREQ: per-requester operand valid.
- `req_ready`, out, NREQ: per-requester accept; one-hot or zero.
- `req_a`, in, NREQ×N: packed operand A; requester i uses bits [i*N +: N].
- `req_b`, in, NREQ×N: packed operand B, same packing as `req_a`.
- `rsp_valid`, out, 1: result valid.
- `rsp_ready`, in, 1: downstream accept.
- `rsp_y`, out, N: rounded, saturated product.
- `rsp_id`, out, IDW: index of the requester that issued the operands.
- `rsp_sat`, out, 1: set when `rsp_y` was clamped.

## Operation
- Arithmetic:
  - Full product is 2N bits, signed.
  - Rounding adds 2^(F-1), then shifts right arithmetically by F (round half toward +inf).
  - The result clamps to [-2^(N-1), 2^(N-1)-1].
  - `rsp_sat` = 1 when the pre-clamp value is out of range.
- Pipeline: S1 holds operands and id. S2 holds `rsp_y`, `rsp_id`, `rsp_sat`. S2 drives the response port directly.
- Advance rules:
  - `adv2 = !s2_valid | rsp_ready`
  - `adv1 = !s1_valid | adv2`
  - Issue is allowed only when `adv1`.
- Arbitration:
  - The rotating pointer `ptr` gives priority order ptr, ptr+1, …, NREQ-1, 0, ….
  - The first requester in that order with `req_valid` set is granted, only when `adv1`.
  - `req_ready` = grant. It depends combinationally on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
  - After a grant to index g, `ptr` becomes (g+1) mod NREQ. With no grant, `ptr` holds.
- Requester rule: once `req_valid` is asserted, the requester holds it and its operands until `req_ready`.
- Response rule: while `rsp_valid && !rsp_ready`, `rsp_y`, `rsp_id` and `rsp_sat` stay stable.
- Throughput: 1 result per cycle when `rsp_ready` is held at 1.
- Fairness: a continuously requesting port waits at most NREQ-1 grants.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_y` = 0, `rsp_id` = 0, `rsp_sat` = 0.
  - S1 empty, `ptr` = 0.
- Latency: a grant in cycle t gives `rsp_valid` = 1 in cycle t+2, with no stall.
- Backpressure: with `rsp_ready` = 0 and both stages full, `req_ready` = 0. The first `rsp_ready` = 1 allows a grant in that same cycle (bubble-free).
- Simultaneous events: in one cycle, S2 can be consumed, S1 can move into S2, and a new grant can load S1.
- Reset mid-operation: in-flight S1/S2 contents are discarded without a response, and `ptr` returns to 0. Any requester whose operands sat in S1/S2 must re-issue them itself.

## Structure
- `fxp_pkg` provides `rshift_round` and `sat_signed`. Add to `fxp_pkg`:
  - function `sat_flag#(N)`, returning the out-of-range bit;
  - `typedef fxp_rsp_t`, a struct {y, id, sat}.
- Instance the existing combinational `fxp_mul` between S1 and S2, with `sat_flag` computed alongside it.
- One sub-module, `rr_arbiter #(NREQ)`:
  - inputs: req vector, enable (`adv1`);
  - outputs: one-hot grant, encoded index;
  - owns `ptr`.

## Test plan
- Single request, N=8, F=7:
  - req0 a=0x40, b=0x40 → 2 cycles later `rsp_y`=0x20, `rsp_id`=0, `rsp_sat`=0.
- Rounding and signs:
  - req1 a=0x01, b=0x40 → `rsp_y`=0x01.
  - req2 a=0x60, b=0xA0 → `rsp_y`=0xB8.
- Saturation: req3 a=0x80, b=0x80 → `rsp_y`=0x7F, `rsp_sat`=1.
- All four valid continuously, `rsp_ready`=1:
  - ids appear 0,1,2,3,0,1,… one per cycle;
  - no requester is skipped.
- `rsp_ready` low for 5 cycles with traffic:
  - at most 2 grants, then `req_ready`=0;
  - `rsp_*` stable throughout;
  - ids in order, nothing lost or duplicated once released.
- `rst_n` asserted while S1 and S2 are full:
  - outputs go to reset values immediately (asynchronous);
  - after release, req2 alone is granted first with `ptr`=0 order; no stale response appears.

Source files
------------

// File: rtl/fxp_pkg.sv
// Fixed-point helpers shared by the multiplier tiles: rounding, clamping and
// the response record returned by the shared-multiplier arbiter.
package fxp_pkg;

    localparam int unsigned FXP_WMAX    = 64;
    localparam int unsigned FXP_NMAX    = 16;
    localparam int unsigned FXP_IDW_MAX = 3;

    typedef logic signed [FXP_WMAX-1:0] fxp_wide_t;

    localparam fxp_wide_t FXP_ONE = 64'sd1;

    typedef struct packed {
        logic signed [FXP_NMAX-1:0]    y;
        logic        [FXP_IDW_MAX-1:0] id;
        logic                          sat;
    } fxp_rsp_t;

    // Round half toward +inf: add 2^(f-1), then arithmetic shift by f.
    function automatic fxp_wide_t rshift_round(input fxp_wide_t p, input int unsigned f);
        return (p + (FXP_ONE << (f - 1))) >>> f;
    endfunction

    function automatic fxp_wide_t sat_signed(input fxp_wide_t v, input int unsigned n);
        fxp_wide_t lim;
        lim = FXP_ONE << (n - 1);
        if (v > lim - FXP_ONE) return lim - FXP_ONE;
        if (v < -lim)          return -lim;
        return v;
    endfunction

    function automatic logic sat_flag(input fxp_wide_t v, input int unsigned n);
        fxp_wide_t lim;
        lim = FXP_ONE << (n - 1);
        return (v > lim - FXP_ONE) || (v < -lim);
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// Combinational Q(N-F).F multiplier: rounded pre-clamp value and saturated result.
module fxp_mul
    import fxp_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned F = 7
) (
    input  logic signed [N-1:0]   a,
    input  logic signed [N-1:0]   b,
    output logic signed [N-1:0]   y,
    output logic signed [2*N-1:0] r
);

    // The rounded product always fits in 2N bits, so r loses nothing.
    assign r = (2*N)'(rshift_round(fxp_wide_t'(a) * fxp_wide_t'(b), F));
    assign y = N'(sat_signed(fxp_wide_t'(r), N));

endmodule

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: search starts at ptr, ptr moves past each grant.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] ptr;
    logic           found;
    int unsigned    cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req[IDW'(cand)]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
        if (en && found) gnt[idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (en && found)
            ptr <= (32'(idx) == NREQ - 1) ? '0 : idx + 1'b1;
    end

endmodule

// File: rtl/fxp_mul_arb.sv
// Shares one fxp_mul between NREQ valid/ready requesters through a 2-stage
// pipeline; results come back tagged with requester id and saturation flag.
module fxp_mul_arb
    import fxp_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned N    = 8,
    parameter int unsigned F    = 7,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [N-1:0]      rsp_y,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_sat
);

    logic                 adv1, adv2;
    logic                 s1_valid, s2_valid;
    logic [NREQ-1:0]      gnt;
    logic [IDW-1:0]       gidx, s1_id;
    logic signed [N-1:0]  s1_a, s1_b, mul_y;
    logic signed [2*N-1:0] mul_r;
    logic                 mul_sat;

    assign adv2      = !s2_valid || rsp_ready;
    assign adv1      = !s1_valid || adv2;
    assign req_ready = gnt;
    assign rsp_valid = s2_valid;

    // Gating with rst_n keeps req_ready low while reset is held.
    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (adv1 && rst_n),
        .gnt   (gnt),
        .idx   (gidx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_id    <= '0;
        end else if (adv1) begin
            s1_valid <= |gnt;
            if (|gnt) begin
                s1_a  <= req_a[32'(gidx)*N +: N];
                s1_b  <= req_b[32'(gidx)*N +: N];
                s1_id <= gidx;
            end
        end
    end

    fxp_mul #(.N(N), .F(F)) u_mul (
        .a (s1_a),
        .b (s1_b),
        .y (mul_y),
        .r (mul_r)
    );

    assign mul_sat = sat_flag(fxp_wide_t'(mul_r), N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            rsp_y    <= '0;
            rsp_id   <= '0;
            rsp_sat  <= 1'b0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                rsp_y   <= mul_y;
                rsp_id  <= s1_id;
                rsp_sat <= mul_sat;
            end
        end
    end

endmodule
